// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg -- shared definitions for the SPI main controller.
//
// Contents:
//   SPI_CPOL / SPI_CPHA : SPI mode constants (Mode 0: CPOL=0, CPHA=0)
//   spi_state_e         : controller FSM states (IDLE, SETUP, SHIFT, HOLD)
//   clog2_min1()        : $clog2 that never returns 0, for counter widths
// ---------------------------------------------------------------------------
package spi_pkg;

    // Serial clock idle level and sampling phase.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // Counter width for a range of v values; at least one bit so that
    // degenerate parameters (v = 1) still produce a legal vector.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div -- half-period tick generator for the SPI serial clock.
//
// Parameters:
//   CLK_DIV : clk cycles per sclk half-period (>= 1)
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   i_en   in  run the counter; held at zero while low
//   o_tick out high in the last clk cycle of each half-period
// ---------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int DIV_W = clog2_min1(CLK_DIV);

    logic [DIV_W-1:0] r_cnt;

    // With CLK_DIV = 1 the counter sits at zero and every enabled cycle ticks.
    assign o_tick = i_en && (r_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_main.sv
// ---------------------------------------------------------------------------
// spi_main -- SPI Mode 0 main (controller), one word per transfer, MSB first.
//
// Parameters:
//   DATA_W  : bits per transfer (>= 1)
//   CLK_DIV : clk cycles per sclk half-period (>= 1)
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_valid  in   start request; accepted when tx_valid && tx_ready
//   tx_ready  out  controller can accept tx_data this cycle
//   tx_data   in   word shifted out on mosi
//   rx_valid  out  one-cycle pulse, rx_data just updated
//   rx_data   out  word sampled from miso, stable between pulses
//   sclk      out  serial clock (idle low)
//   mosi      out  serial data out, low while cs_n is high
//   miso      in   serial data in, ignored while cs_n is high
//   cs_n      out  chip select, active low
//
// Optional build macro: SPI_MAIN_BURST_EN
//   When defined, a new word may be accepted in the last sclk-high cycle of
//   the current word. The accepting edge is also the final sclk fall: cs_n
//   stays low, rx_valid pulses and the new MSB appears on mosi right after
//   it, and the next rise follows one half-period later (HOLD and SETUP are
//   skipped). Without the macro, cs_n always returns high between words.
//
// Timing (accept at end of cycle T0): cs_n low and MSB on mosi at T0+1,
// first sclk rise at T0+1+CLK_DIV, rx_valid at T0+1+CLK_DIV*(2*DATA_W+2).
// ---------------------------------------------------------------------------
module spi_main
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    // Counts completed sclk falls, so it must reach DATA_W itself.
    localparam int BIT_W = clog2_min1(DATA_W + 1);

    spi_state_e        r_state;
    logic              r_rdy_en;
    logic              r_cs_n;
    logic              r_sclk;
    logic              r_rx_valid;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [BIT_W-1:0]  r_bit_cnt;

    logic w_tick;
    logic w_leading;
    logic w_sample;
    logic w_launch;
    logic w_all_done;
    logic w_burst_slot;
    logic w_accept;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    // Leading edge = sclk leaving its idle level. With CPHA=0 data is
    // sampled on the leading edge and launched on the trailing edge.
    assign w_leading  = (r_sclk == SPI_CPOL);
    assign w_sample   = w_tick && (w_leading ^ SPI_CPHA);
    assign w_launch   = w_tick && !(w_leading ^ SPI_CPHA);
    assign w_all_done = (r_bit_cnt == BIT_W'(DATA_W));

`ifdef SPI_MAIN_BURST_EN
    logic w_last_bit;
    assign w_last_bit   = (r_bit_cnt == BIT_W'(DATA_W - 1));
    // Last sclk-high cycle of the word: its closing edge is the final fall.
    assign w_burst_slot = (r_state == ST_SHIFT) && w_launch && w_last_bit;
`else
    assign w_burst_slot = 1'b0;
`endif

    // r_rdy_en keeps tx_ready low during reset and until the first edge after it.
    assign tx_ready = r_rdy_en && ((r_state == ST_IDLE) || w_burst_slot);
    assign w_accept = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rdy_en   <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sclk     <= SPI_CPOL;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_SETUP;
                        r_cs_n    <= 1'b0;
                        r_tx_sh   <= tx_data;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    // End of setup half-period is the first rise: sample bit 1.
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                        r_sclk  <= ~SPI_CPOL;
                        r_rx_sh <= (r_rx_sh << 1) | DATA_W'(miso);
                    end
                end
                ST_SHIFT: begin
                    if (w_sample) begin
                        // After the last fall, the low half-period that would
                        // have ended in a rise instead ends the shift phase.
                        if (w_all_done) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_sclk  <= ~SPI_CPOL;
                            r_rx_sh <= (r_rx_sh << 1) | DATA_W'(miso);
                        end
                    end else if (w_launch) begin
                        r_sclk <= SPI_CPOL;
                        if (w_accept) begin
                            // Back-to-back word: rx_sh is complete after the
                            // last rise, so hand it over on this fall.
                            r_tx_sh    <= tx_data;
                            r_bit_cnt  <= '0;
                            r_rx_data  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_tx_sh   <= r_tx_sh << 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_state    <= ST_IDLE;
                        r_cs_n     <= 1'b1;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_sh;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cs_n     = r_cs_n;
    assign sclk     = r_sclk;
    assign mosi     = !r_cs_n && r_tx_sh[DATA_W-1];
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_main.sv
// ---------------------------------------------------------------------------
// tb_spi_main -- self-checking bench for spi_main.
// DUT8: DATA_W=8, CLK_DIV=2 (table of directed words, back-pressure,
// mid-transfer reset, burst when SPI_MAIN_BURST_EN is defined).
// DUT1: DATA_W=1, CLK_DIV=1 (minimum-size latency corner).
// ---------------------------------------------------------------------------
module tb_spi_main;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT8 signals
    logic       tv8, tr8, rv8, sclk8, mosi8, miso8, cs8;
    logic [7:0] td8, rd8;
    // DUT1 signals
    logic       tv1, tr1, rv1, sclk1, mosi1, miso1, cs1;
    logic [0:0] td1, rd1;

    spi_main #(.DATA_W(8), .CLK_DIV(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tv8), .tx_ready(tr8), .tx_data(td8),
        .rx_valid(rv8), .rx_data(rd8), .sclk(sclk8), .mosi(mosi8), .miso(miso8), .cs_n(cs8)
    );

    spi_main #(.DATA_W(1), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tv1), .tx_ready(tr1), .tx_data(td1),
        .rx_valid(rv1), .rx_data(rd1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- cycle counter and DUT8 monitor / secondary model ----
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        lb;          // 1: miso looped back from mosi
    logic [7:0]  sl_word;     // word returned by the secondary model
    logic        sl_bit = 1'b0;
    assign miso8 = lb ? mosi8 : sl_bit;

    int          rises = 0, acc_cnt = 0, rv_cnt = 0, cs_rise = 0, viol = 0;
    int          t_acc = 0, t_acc_prev = 0, t_rv = 0, t_rv_prev = 0;
    logic [7:0]  rv_d = 0, rv_d_prev = 0, rd_hold = 0;
    logic [15:0] mosi_cap = 0;
    logic        prev_sclk = 0, prev_cs = 1;
    int          fall_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tv8 && tr8) begin
                acc_cnt++; t_acc_prev = t_acc; t_acc = cyc;
            end
            if (rv8) begin
                rv_cnt++; t_rv_prev = t_rv; t_rv = cyc; rv_d_prev = rv_d; rv_d = rd8;
            end else if (rd8 !== rd_hold) begin
                viol++;
            end
            if (sclk8 && !prev_sclk) begin
                rises++; mosi_cap = {mosi_cap[14:0], mosi8};
            end
            if (cs8 && (mosi8 || sclk8)) viol++;
`ifndef SPI_MAIN_BURST_EN
            if (tr8 && !cs8) viol++;
`endif
            if (cs8 && !prev_cs) cs_rise++;
        end
        rd_hold = rd8;
        // Mode 0 secondary: MSB valid when selected, next bit after each fall.
        if (cs8) fall_cnt = 0;
        else if (prev_sclk && !sclk8) fall_cnt++;
        sl_bit = (!cs8 && fall_cnt < 8) ? sl_word[7 - fall_cnt] : 1'b0;
        prev_sclk = sclk8;
        prev_cs   = cs8;
    end

    // ---------------- DUT8 helpers ----------------
    task automatic wait_ready8(output logic to);
        int n = 0;
        to = 1'b1;
        while (n < 100) begin
            @(posedge clk); #1;
            if (tr8) begin to = 1'b0; break; end
            n++;
        end
    endtask

    task automatic wait_rv8(output logic to);
        int n = 0;
        to = 1'b1;
        while (n < 200) begin
            @(posedge clk); #1;
            if (rv8) begin to = 1'b0; break; end
            n++;
        end
    endtask

    task automatic xfer8(input logic [7:0] d, output logic to);
        logic t1, t2;
        wait_ready8(t1);
        tv8 = 1'b1; td8 = d;
        @(posedge clk); #1;
        tv8 = 1'b0;
        wait_rv8(t2);
        @(posedge clk); #1;   // let the monitor see the rx_valid cycle
        to = t1 | t2;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       lb;
        logic [7:0] sw;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    typedef struct {
        logic [0:0] tx;
        logic       mi;
        logic [0:0] exp_rx;
    } vec1_t;

    initial begin
        vec_t  vecs [5];
        vec1_t v1s  [3];
        logic  to;
        int    r0, a0, c0, v0;

        vecs[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{8'hC3, 1'b0, 8'h3C, 8'h3C, 8'hC3};
        vecs[2] = '{8'h00, 1'b0, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{8'h81, 1'b0, 8'h7E, 8'h7E, 8'h81};
        v1s[0]  = '{1'b1, 1'b1, 1'b1};
        v1s[1]  = '{1'b1, 1'b0, 1'b0};
        v1s[2]  = '{1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; tv8 = 1'b0; td8 = 8'h00; lb = 1'b1; sl_word = 8'h00;
        tv1 = 1'b0; td1 = 1'b0; miso1 = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs8, 1'b1);
        chk("rst_sclk", sclk8, 1'b0);
        chk("rst_mosi", mosi8, 1'b0);
        chk("rst_tx_ready", tr8, 1'b0);
        chk("rst_rx_valid", rv8, 1'b0);
        chk("rst_rx_data", rd8, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", tr8, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_edge", tr8, 1'b1);

        // ---- table of single transfers ----
        for (int i = 0; i < 5; i++) begin
            lb = vecs[i].lb; sl_word = vecs[i].sw;
            r0 = rises; v0 = rv_cnt;
            xfer8(vecs[i].tx, to);
            $display("xfer %0d: tx=%02h rx=%02h mosi=%02h rises=%0d latency=%0d",
                     i, vecs[i].tx, rd8, mosi_cap[7:0], rises - r0, t_rv - t_acc);
            chk("xfer_timeout", to, 1'b0);
            chk("xfer_rx_data", rd8, vecs[i].exp_rx);
            chk("xfer_mosi_bits", mosi_cap[7:0], vecs[i].exp_mosi);
            chk("xfer_rises", rises - r0, 8);
            chk("xfer_latency", t_rv - t_acc, 37);
            chk("xfer_rv_pulses", rv_cnt - v0, 1);
        end

`ifndef SPI_MAIN_BURST_EN
        // ---- tx_valid held high with changing tx_data: no queuing ----
        lb = 1'b1;
        a0 = acc_cnt; c0 = cs_rise;
        wait_ready8(to);
        chk("hold_ready_timeout", to, 1'b0);
        tv8 = 1'b1; td8 = 8'h11;
        @(posedge clk); #1;
        to = 1'b1;
        for (int n = 0; n < 200; n++) begin
            td8 = td8 + 8'h11;
            @(posedge clk); #1;
            if (rv8) begin to = 1'b0; break; end
        end
        td8 = 8'h77;          // presented in the IDLE cycle: becomes word 2
        chk("hold_first_timeout", to, 1'b0);
        chk("hold_first_rx", rd8, 8'h11);
        chk("hold_first_mosi", mosi_cap[7:0], 8'h11);
        @(posedge clk); #1;
        tv8 = 1'b0;
        wait_rv8(to);
        @(posedge clk); #1;
        $display("held valid: word1=11 word2 rx=%02h mosi=%02h", rd8, mosi_cap[7:0]);
        chk("hold_second_timeout", to, 1'b0);
        chk("hold_second_rx", rd8, 8'h77);
        chk("hold_second_mosi", mosi_cap[7:0], 8'h77);
        chk("hold_accepts", acc_cnt - a0, 2);
        chk("hold_cs_gaps", cs_rise - c0, 2);
`endif

        // ---- reset at the 4th sclk rise ----
        lb = 1'b1;
        v0 = rv_cnt;
        wait_ready8(to);
        tv8 = 1'b1; td8 = 8'hF0;
        @(posedge clk); #1;
        tv8 = 1'b0;
        begin
            int   rc = 0;
            logic ps = 1'b0;
            to = 1'b1;
            for (int n = 0; n < 100; n++) begin
                if (sclk8 && !ps) rc++;
                ps = sclk8;
                if (rc == 4) begin to = 1'b0; break; end
                @(posedge clk); #1;
            end
        end
        chk("abort_rise_timeout", to, 1'b0);
        chk("abort_pre_cs_n", cs8, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs8, 1'b1);
        chk("abort_sclk", sclk8, 1'b0);
        chk("abort_ready", tr8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_rx_data", rd8, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_rv", rv_cnt - v0, 0);
        xfer8(8'h5A, to);
        $display("after abort: tx=5A rx=%02h latency=%0d", rd8, t_rv - t_acc);
        chk("abort_next_timeout", to, 1'b0);
        chk("abort_next_rx", rd8, 8'h5A);
        chk("abort_next_latency", t_rv - t_acc, 37);
        chk("abort_next_pulses", rv_cnt - v0, 1);

`ifdef SPI_MAIN_BURST_EN
        // ---- burst: two words with cs_n held low ----
        lb = 1'b1;
        r0 = rises; v0 = rv_cnt; c0 = cs_rise; a0 = acc_cnt;
        wait_ready8(to);
        tv8 = 1'b1; td8 = 8'h01;
        @(posedge clk); #1;
        td8 = 8'h80;
        to = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (acc_cnt - a0 >= 2) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        tv8 = 1'b0;
        chk("burst_accept_timeout", to, 1'b0);
        to = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (rv_cnt - v0 >= 2) begin to = 1'b0; break; end
        end
        $display("burst: rx1=%02h rx2=%02h rises=%0d mosi=%04h", rv_d_prev, rv_d, rises - r0, mosi_cap);
        chk("burst_rv_timeout", to, 1'b0);
        chk("burst_rises", rises - r0, 16);
        chk("burst_rv_pulses", rv_cnt - v0, 2);
        chk("burst_cs_rises", cs_rise - c0, 1);
        chk("burst_rx1", rv_d_prev, 8'h01);
        chk("burst_rx2", rv_d, 8'h80);
        chk("burst_mosi", mosi_cap, 16'h0180);
        chk("burst_accept_gap", t_acc - t_acc_prev, 32);
        chk("burst_rv1_time", t_rv_prev - t_acc_prev, 33);
        chk("burst_rv2_time", t_rv - t_acc, 37);
`endif

        // ---- DATA_W=1, CLK_DIV=1 corner ----
        for (int i = 0; i < 3; i++) begin
            int   t0, trv, hi, n;
            logic got, mb;
            n = 0;
            while (!tr1 && n < 20) begin @(posedge clk); #1; n++; end
            tv1 = 1'b1; td1 = v1s[i].tx; miso1 = v1s[i].mi;
            t0 = cyc; hi = 0; got = 1'b0; trv = 0; mb = 1'b0;
            @(posedge clk); #1;
            tv1 = 1'b0;
            n = 0;
            while (!got && n < 50) begin
                if (sclk1) begin hi++; mb = mosi1; end
                if (rv1) begin got = 1'b1; trv = cyc; end
                else begin @(posedge clk); #1; n++; end
            end
            $display("w1 xfer %0d: tx=%0d miso=%0d rx=%0d latency=%0d", i, v1s[i].tx, v1s[i].mi, rd1, trv - t0);
            chk("w1_timeout", got, 1'b1);
            chk("w1_latency", trv - t0, 5);
            chk("w1_rx_data", rd1, v1s[i].exp_rx);
            chk("w1_sclk_high_cycles", hi, 1);
            chk("w1_mosi_bit", mb, v1s[i].tx);
            @(posedge clk); #1;
        end

        chk("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
